// File: rtl/step_controller_if.sv
// Control/handshake bundle between the step controller and the 10-bit datapath.
// The controller uses the master modport and the datapath/key logic uses the slave modport.
interface step_controller_if;
    logic       exec;
    logic [9:0] instr;
    logic [1:0] step_time;
    logic       clr;
    logic       ext_oe;
    logic       imm_oe;
    logic       r_oe;
    logic [2:0] r_raddr;
    logic       r_we;
    logic [2:0] r_waddr;
    logic       a_ld;
    logic       g_ld;
    logic       g_oe;
    logic [3:0] alu_op;

    modport master (
        input  exec, instr,
        output step_time, clr, ext_oe, imm_oe, r_oe, r_raddr, r_we, r_waddr,
               a_ld, g_ld, g_oe, alu_op
    );

    modport slave (
        output exec, instr,
        input  step_time, clr, ext_oe, imm_oe, r_oe, r_raddr, r_we, r_waddr,
               a_ld, g_ld, g_oe, alu_op
    );
endinterface

// File: rtl/step_controller.sv
// Instruction sequencer: latches an instruction on start and steps T1..T3 driving datapath controls.
// Optional macro STEP_CTRL_EXEC_EDGE_EN makes a start require a rising edge of exec.
module step_controller (
    input  logic               clk,
    input  logic               rst,
    step_controller_if.master  ctrl
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_INV  = 4'b0100;
    localparam logic [3:0] OP_FLIP = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;

    step_t       state_reg;
    logic [9:0]  ir_reg;
    logic        start;

    logic [3:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;

    logic        clr;
    logic        ext_oe;
    logic        imm_oe;
    logic        r_oe;
    logic [2:0]  r_raddr;
    logic        r_we;
    logic [2:0]  r_waddr;
    logic        a_ld;
    logic        g_ld;
    logic        g_oe;
    logic [3:0]  alu_op;

    assign opcode = ir_reg[9:6];
    assign rx     = ir_reg[5:3];
    assign ry     = ir_reg[2:0];

    // Last step per opcode; illegal opcodes retire in T1 like LOAD/COPY.
    function automatic logic [1:0] last_step_of(input logic [3:0] op);
        logic [1:0] result;
        case (op)
            OP_LOAD, OP_COPY:                  result = 2'd1;
            OP_INV, OP_FLIP:                   result = 2'd2;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_ADDI:                   result = 2'd3;
            default:                           result = 2'd1;
        endcase
        return result;
    endfunction

    logic [15:0][1:0] last_step_tab;

    for (genvar gi = 0; gi < 16; gi++) begin : g_last_step
        assign last_step_tab[gi] = last_step_of(4'(gi));
    end

`ifdef STEP_CTRL_EXEC_EDGE_EN
    logic exec_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            exec_prev_reg <= 1'b0;
        end else begin
            exec_prev_reg <= ctrl.exec;
        end
    end

    // Only a fresh press counts; an edge seen mid-instruction is simply lost.
    assign start = ctrl.exec & ~exec_prev_reg;
`else
    assign start = ctrl.exec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= T0;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                T0: begin
                    if (start) begin
                        ir_reg    <= ctrl.instr;
                        state_reg <= T1;
                    end
                end
                default: begin
                    if (clr) begin
                        state_reg <= T0;
                    end else begin
                        state_reg <= step_t'(state_reg + 2'd1);
                    end
                end
            endcase
        end
    end

    // Control decode depends only on registered state, so outputs are glitch-free per cycle.
    always_comb begin
        ext_oe  = 1'b0;
        imm_oe  = 1'b0;
        r_oe    = 1'b0;
        r_raddr = 3'd0;
        r_we    = 1'b0;
        r_waddr = 3'd0;
        a_ld    = 1'b0;
        g_ld    = 1'b0;
        g_oe    = 1'b0;
        alu_op  = 4'd0;
        clr     = (state_reg != T0) && (2'(state_reg) == last_step_tab[opcode]);

        if (state_reg != T0) begin
            alu_op = opcode;
        end

        case (opcode)
            OP_LOAD: begin
                if (state_reg == T1) begin
                    ext_oe  = 1'b1;
                    r_we    = 1'b1;
                    r_waddr = rx;
                end
            end
            OP_COPY: begin
                if (state_reg == T1) begin
                    r_oe    = 1'b1;
                    r_raddr = ry;
                    r_we    = 1'b1;
                    r_waddr = rx;
                end
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                case (state_reg)
                    T1: begin
                        r_oe    = 1'b1;
                        r_raddr = rx;
                        a_ld    = 1'b1;
                    end
                    T2: begin
                        r_oe    = 1'b1;
                        r_raddr = ry;
                        g_ld    = 1'b1;
                    end
                    T3: begin
                        g_oe    = 1'b1;
                        r_we    = 1'b1;
                        r_waddr = rx;
                    end
                    default: ;
                endcase
            end
            OP_INV, OP_FLIP: begin
                case (state_reg)
                    T1: begin
                        r_oe    = 1'b1;
                        r_raddr = ry;
                        g_ld    = 1'b1;
                    end
                    T2: begin
                        g_oe    = 1'b1;
                        r_we    = 1'b1;
                        r_waddr = rx;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                // Immediate comes from Ry; the datapath zero-extends it onto the bus.
                case (state_reg)
                    T1: begin
                        r_oe    = 1'b1;
                        r_raddr = rx;
                        a_ld    = 1'b1;
                    end
                    T2: begin
                        imm_oe  = 1'b1;
                        g_ld    = 1'b1;
                    end
                    T3: begin
                        g_oe    = 1'b1;
                        r_we    = 1'b1;
                        r_waddr = rx;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign ctrl.step_time = 2'(state_reg);
    assign ctrl.clr       = clr;
    assign ctrl.ext_oe    = ext_oe;
    assign ctrl.imm_oe    = imm_oe;
    assign ctrl.r_oe      = r_oe;
    assign ctrl.r_raddr   = r_raddr;
    assign ctrl.r_we      = r_we;
    assign ctrl.r_waddr   = r_waddr;
    assign ctrl.a_ld      = a_ld;
    assign ctrl.g_ld      = g_ld;
    assign ctrl.g_oe      = g_oe;
    assign ctrl.alu_op    = alu_op;

endmodule
